// File: rtl/dphy_tx_hs_seq.sv
// D-PHY transmit HS burst sequencer: raises the clock-lane HS request,
// then the data-lane requests, streams 64-bit beats as four 16-bit lane
// words, and winds the lanes back down to LP with post and gap timing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | LP, waiting for a beat and all lanes in stop state
// CLK_PRE  | clock lane in HS, counting down before data-lane request
// LANE_REQ | data lanes requested, waiting for all lanes ready
// ACTIVE   | accepting beats, one lane word per lane per cycle
// TAIL     | last word on the lanes, requests still high
// CLK_POST | data lanes dropped, clock lane held in HS
// GAP      | all requests low, enforcing LP time before the next burst
module dphy_tx_hs_seq #(
  parameter int CLK_PRE_CYC  = 8,
  parameter int CLK_POST_CYC = 16,
  parameter int HS_GAP_CYC   = 4
) (
  input  logic        SLOWCLK,
  input  logic        RESET,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [63:0] S_DATA,
  input  logic        S_LAST,
  output logic        TX_REQUEST_HS,
  input  logic        STOPSTATE_CLK,
  output logic        TX_REQUEST_HS_LAN0,
  output logic        TX_REQUEST_HS_LAN1,
  output logic        TX_REQUEST_HS_LAN2,
  output logic        TX_REQUEST_HS_LAN3,
  input  logic        TX_READY_HS_LAN0,
  input  logic        TX_READY_HS_LAN1,
  input  logic        TX_READY_HS_LAN2,
  input  logic        TX_READY_HS_LAN3,
  output logic [15:0] TX_DATA_HS_LAN0,
  output logic [15:0] TX_DATA_HS_LAN1,
  output logic [15:0] TX_DATA_HS_LAN2,
  output logic [15:0] TX_DATA_HS_LAN3,
  output logic        TX_WORD_VALID_HS_LAN0,
  output logic        TX_WORD_VALID_HS_LAN1,
  output logic        TX_WORD_VALID_HS_LAN2,
  output logic        TX_WORD_VALID_HS_LAN3,
  input  logic        STOPSTATE_LAN0,
  input  logic        STOPSTATE_LAN1,
  input  logic        STOPSTATE_LAN2,
  input  logic        STOPSTATE_LAN3,
  output logic        BUSY,
  output logic        UNDERRUN
);

  typedef enum logic [2:0] {
    IDLE, CLK_PRE, LANE_REQ, ACTIVE, TAIL, CLK_POST, GAP
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        req_hs;
  logic        lane_req;
  logic        word_valid;
  logic        underrun_q;
  logic [15:0] d0, d1, d2, d3;
  logic        all_ready;
  logic        all_stop;

  assign all_ready = TX_READY_HS_LAN0 & TX_READY_HS_LAN1 & TX_READY_HS_LAN2 & TX_READY_HS_LAN3;
  assign all_stop  = STOPSTATE_CLK & STOPSTATE_LAN0 & STOPSTATE_LAN1 & STOPSTATE_LAN2 & STOPSTATE_LAN3;

  assign S_READY = (state == ACTIVE) & all_ready;
  assign BUSY    = (state != IDLE);

  assign TX_REQUEST_HS      = req_hs;
  assign TX_REQUEST_HS_LAN0 = lane_req;
  assign TX_REQUEST_HS_LAN1 = lane_req;
  assign TX_REQUEST_HS_LAN2 = lane_req;
  assign TX_REQUEST_HS_LAN3 = lane_req;

  assign TX_WORD_VALID_HS_LAN0 = word_valid;
  assign TX_WORD_VALID_HS_LAN1 = word_valid;
  assign TX_WORD_VALID_HS_LAN2 = word_valid;
  assign TX_WORD_VALID_HS_LAN3 = word_valid;

  assign TX_DATA_HS_LAN0 = d0;
  assign TX_DATA_HS_LAN1 = d1;
  assign TX_DATA_HS_LAN2 = d2;
  assign TX_DATA_HS_LAN3 = d3;

  assign UNDERRUN = underrun_q;

  // Sequencer FSM with the shared down-counter and all registered outputs.
  always_ff @(posedge SLOWCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      req_hs     <= 1'b0;
      lane_req   <= 1'b0;
      word_valid <= 1'b0;
      underrun_q <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
    end else begin
      word_valid <= 1'b0;
      underrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (S_VALID && all_stop) begin
            state  <= CLK_PRE;
            req_hs <= 1'b1;
            cnt    <= 8'(CLK_PRE_CYC - 1);
          end
        end
        CLK_PRE: begin
          if (cnt == 8'd0) begin
            state    <= LANE_REQ;
            lane_req <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LANE_REQ: begin
          if (all_ready) state <= ACTIVE;
        end
        ACTIVE: begin
          // A ready slot with no beat is a hole in the HS stream.
          if (all_ready) begin
            if (S_VALID) begin
              word_valid <= 1'b1;
              d0         <= S_DATA[15:0];
              d1         <= S_DATA[31:16];
              d2         <= S_DATA[47:32];
              d3         <= S_DATA[63:48];
              if (S_LAST) state <= TAIL;
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end
        TAIL: begin
          state    <= CLK_POST;
          lane_req <= 1'b0;
          cnt      <= 8'(CLK_POST_CYC - 1);
        end
        CLK_POST: begin
          if (cnt == 8'd0) begin
            state  <= GAP;
            req_hs <= 1'b0;
            cnt    <= 8'(HS_GAP_CYC);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          // The LP gap only starts counting once every lane is really in stop.
          if (!all_stop)          cnt   <= 8'(HS_GAP_CYC);
          else if (cnt == 8'd0)   state <= IDLE;
          else                    cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_tx_hs_seq.sv
// Bench for dphy_tx_hs_seq: reset checks, a start-condition vector table,
// directed multi-cycle sequences and a randomized run against a
// transaction-level reference of the burst rules.
module tb_dphy_tx_hs_seq;

  localparam int PRE  = 8;
  localparam int POST = 16;
  localparam int GAPC = 4;

  logic        SLOWCLK = 1'b0;
  logic        RESET;
  logic        S_VALID;
  logic        S_READY;
  logic [63:0] S_DATA;
  logic        S_LAST;
  logic        TX_REQUEST_HS;
  logic        STOPSTATE_CLK;
  logic        TX_REQUEST_HS_LAN0, TX_REQUEST_HS_LAN1, TX_REQUEST_HS_LAN2, TX_REQUEST_HS_LAN3;
  logic        TX_READY_HS_LAN0, TX_READY_HS_LAN1, TX_READY_HS_LAN2, TX_READY_HS_LAN3;
  logic [15:0] TX_DATA_HS_LAN0, TX_DATA_HS_LAN1, TX_DATA_HS_LAN2, TX_DATA_HS_LAN3;
  logic        TX_WORD_VALID_HS_LAN0, TX_WORD_VALID_HS_LAN1, TX_WORD_VALID_HS_LAN2, TX_WORD_VALID_HS_LAN3;
  logic        STOPSTATE_LAN0, STOPSTATE_LAN1, STOPSTATE_LAN2, STOPSTATE_LAN3;
  logic        BUSY;
  logic        UNDERRUN;

  // Simple PHY model: a lane sits in stop whenever it is not requested,
  // unless the bench forces its stop state low.
  logic       stop_clk_en;
  logic [3:0] stop_lan_en;
  assign STOPSTATE_CLK  = stop_clk_en    & ~TX_REQUEST_HS;
  assign STOPSTATE_LAN0 = stop_lan_en[0] & ~TX_REQUEST_HS_LAN0;
  assign STOPSTATE_LAN1 = stop_lan_en[1] & ~TX_REQUEST_HS_LAN1;
  assign STOPSTATE_LAN2 = stop_lan_en[2] & ~TX_REQUEST_HS_LAN2;
  assign STOPSTATE_LAN3 = stop_lan_en[3] & ~TX_REQUEST_HS_LAN3;

  dphy_tx_hs_seq #(.CLK_PRE_CYC(PRE), .CLK_POST_CYC(POST), .HS_GAP_CYC(GAPC)) dut (
    .SLOWCLK(SLOWCLK), .RESET(RESET),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .TX_REQUEST_HS(TX_REQUEST_HS), .STOPSTATE_CLK(STOPSTATE_CLK),
    .TX_REQUEST_HS_LAN0(TX_REQUEST_HS_LAN0), .TX_REQUEST_HS_LAN1(TX_REQUEST_HS_LAN1),
    .TX_REQUEST_HS_LAN2(TX_REQUEST_HS_LAN2), .TX_REQUEST_HS_LAN3(TX_REQUEST_HS_LAN3),
    .TX_READY_HS_LAN0(TX_READY_HS_LAN0), .TX_READY_HS_LAN1(TX_READY_HS_LAN1),
    .TX_READY_HS_LAN2(TX_READY_HS_LAN2), .TX_READY_HS_LAN3(TX_READY_HS_LAN3),
    .TX_DATA_HS_LAN0(TX_DATA_HS_LAN0), .TX_DATA_HS_LAN1(TX_DATA_HS_LAN1),
    .TX_DATA_HS_LAN2(TX_DATA_HS_LAN2), .TX_DATA_HS_LAN3(TX_DATA_HS_LAN3),
    .TX_WORD_VALID_HS_LAN0(TX_WORD_VALID_HS_LAN0), .TX_WORD_VALID_HS_LAN1(TX_WORD_VALID_HS_LAN1),
    .TX_WORD_VALID_HS_LAN2(TX_WORD_VALID_HS_LAN2), .TX_WORD_VALID_HS_LAN3(TX_WORD_VALID_HS_LAN3),
    .STOPSTATE_LAN0(STOPSTATE_LAN0), .STOPSTATE_LAN1(STOPSTATE_LAN1),
    .STOPSTATE_LAN2(STOPSTATE_LAN2), .STOPSTATE_LAN3(STOPSTATE_LAN3),
    .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  always #5 SLOWCLK = ~SLOWCLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic       sc;
    logic [3:0] sl;
    logic       exp_go;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SLOWCLK);
    #1;
  endtask

  function automatic logic [63:0] lanes();
    return {TX_DATA_HS_LAN3, TX_DATA_HS_LAN2, TX_DATA_HS_LAN1, TX_DATA_HS_LAN0};
  endfunction

  function automatic logic [3:0] valids();
    return {TX_WORD_VALID_HS_LAN3, TX_WORD_VALID_HS_LAN2, TX_WORD_VALID_HS_LAN1, TX_WORD_VALID_HS_LAN0};
  endfunction

  function automatic logic [3:0] lreqs();
    return {TX_REQUEST_HS_LAN3, TX_REQUEST_HS_LAN2, TX_REQUEST_HS_LAN1, TX_REQUEST_HS_LAN0};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return TX_REQUEST_HS;
      1:       return TX_REQUEST_HS_LAN0;
      2:       return S_READY;
      default: return BUSY;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input int max, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      total++;
      bad++;
      $display("FAIL wait_timeout sel=%0d got %b want %b", sel, sig(sel), lvl);
    end
  endtask

  task automatic set_ready(input logic [3:0] r);
    {TX_READY_HS_LAN3, TX_READY_HS_LAN2, TX_READY_HS_LAN1, TX_READY_HS_LAN0} = r;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Deliver one final beat to whatever burst is in progress and wait for LP.
  task automatic finish_burst(input logic [63:0] d);
    int n;
    S_VALID = 1'b1;
    S_DATA  = d;
    S_LAST  = 1'b1;
    wait_sig(2, 1'b1, 100, n);
    tick();
    check("fin_word", lanes(), d);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    wait_sig(3, 1'b0, 100, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int bursts;
    int rem;
    int since;
    logic [63:0] beat;
    logic [63:0] prev_d;
    logic [63:0] exp_d;
    logic exp_v, exp_u;

    vecs[0] = '{v: 1'b1, sc: 1'b1, sl: 4'hf, exp_go: 1'b1};
    vecs[1] = '{v: 1'b0, sc: 1'b1, sl: 4'hf, exp_go: 1'b0};
    vecs[2] = '{v: 1'b1, sc: 1'b0, sl: 4'hf, exp_go: 1'b0};
    vecs[3] = '{v: 1'b1, sc: 1'b1, sl: 4'he, exp_go: 1'b0};
    vecs[4] = '{v: 1'b1, sc: 1'b1, sl: 4'h7, exp_go: 1'b0};
    vecs[5] = '{v: 1'b1, sc: 1'b1, sl: 4'hb, exp_go: 1'b0};

    RESET       = 1'b1;
    S_VALID     = 1'b1;
    S_DATA      = 64'hdead_beef_cafe_f00d;
    S_LAST      = 1'b0;
    stop_clk_en = 1'b1;
    stop_lan_en = 4'hf;
    set_ready(4'hf);

    // Reset state with inputs that would otherwise start a burst.
    tick();
    tick();
    check("rst_req_hs", TX_REQUEST_HS, 1'b0);
    check("rst_lane_req", lreqs(), 4'h0);
    check("rst_valids", valids(), 4'h0);
    check("rst_data", lanes(), 64'h0);
    check("rst_ready", S_READY, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_underrun", UNDERRUN, 1'b0);
    RESET   = 1'b0;
    S_VALID = 1'b0;

    // Start-condition table: burst starts only with a beat and every lane in stop.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      S_VALID     = vecs[i].v;
      stop_clk_en = vecs[i].sc;
      stop_lan_en = vecs[i].sl;
      tick();
      check($sformatf("vec%0d_req_hs", i), TX_REQUEST_HS, vecs[i].exp_go);
      check($sformatf("vec%0d_busy", i), BUSY, vecs[i].exp_go);
      check($sformatf("vec%0d_lane_req", i), lreqs(), 4'h0);
    end
    S_VALID     = 1'b0;
    stop_clk_en = 1'b1;
    stop_lan_en = 4'hf;
    do_reset();

    // Default three-beat burst timing.
    S_VALID = 1'b1;
    S_DATA  = 64'h0123_4567_89ab_cdef;
    S_LAST  = 1'b0;
    tick();
    check("t0_req_hs", TX_REQUEST_HS, 1'b1);
    check("t0_lane_req", lreqs(), 4'h0);
    wait_sig(1, 1'b1, 40, n);
    check("clk_pre_len", n, PRE);
    check("lanes_together", lreqs(), 4'hf);
    check("lanereq_s_ready", S_READY, 1'b0);
    tick();
    check("active_s_ready", S_READY, 1'b1);
    tick();
    check("b0_valid", valids(), 4'hf);
    check("b0_data", lanes(), 64'h0123_4567_89ab_cdef);
    S_DATA = 64'h1111_2222_3333_4444;
    tick();
    check("b1_data", lanes(), 64'h1111_2222_3333_4444);
    S_DATA = 64'h5555_6666_7777_8888;
    S_LAST = 1'b1;
    tick();
    check("b2_valid", valids(), 4'hf);
    check("b2_data", lanes(), 64'h5555_6666_7777_8888);
    check("tail_lane_req", lreqs(), 4'hf);
    check("tail_s_ready", S_READY, 1'b0);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    tick();
    check("post_lane_req", lreqs(), 4'h0);
    check("post_valid", valids(), 4'h0);
    check("post_req_hs", TX_REQUEST_HS, 1'b1);
    check("post_hold", lanes(), 64'h5555_6666_7777_8888);
    wait_sig(0, 1'b0, 40, n);
    check("clk_post_len", n, POST);
    wait_sig(3, 1'b0, 40, n);
    check("gap_len", n, GAPC + 1);

    // Two-cycle hole in the beat stream.
    S_VALID = 1'b1;
    S_DATA  = 64'haaaa_bbbb_cccc_dddd;
    S_LAST  = 1'b0;
    wait_sig(2, 1'b1, 60, n);
    tick();
    check("ur_first_word", lanes(), 64'haaaa_bbbb_cccc_dddd);
    S_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("ur%0d_pulse", i), UNDERRUN, 1'b1);
      check($sformatf("ur%0d_valid", i), valids(), 4'h0);
      check($sformatf("ur%0d_lane_req", i), lreqs(), 4'hf);
    end
    S_VALID = 1'b1;
    S_DATA  = 64'h0f0f_1e1e_2d2d_3c3c;
    S_LAST  = 1'b1;
    tick();
    check("ur_resume_pulse", UNDERRUN, 1'b0);
    check("ur_resume_valid", valids(), 4'hf);
    check("ur_resume_data", lanes(), 64'h0f0f_1e1e_2d2d_3c3c);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    wait_sig(3, 1'b0, 60, n);

    // Lane 2 late to become ready, then a single-beat burst.
    set_ready(4'hb);
    S_VALID = 1'b1;
    S_DATA  = 64'h4444_3333_2222_1111;
    S_LAST  = 1'b1;
    wait_sig(1, 1'b1, 40, n);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lr%0d_s_ready", i), S_READY, 1'b0);
      check($sformatf("lr%0d_valid", i), valids(), 4'h0);
      check($sformatf("lr%0d_busy", i), BUSY, 1'b1);
      tick();
    end
    check("lr_s_ready_still", S_READY, 1'b0);
    set_ready(4'hf);
    tick();
    check("lr_released", S_READY, 1'b1);
    tick();
    check("sb_valid", valids(), 4'hf);
    check("sb_lan0", TX_DATA_HS_LAN0, 16'h1111);
    check("sb_lan1", TX_DATA_HS_LAN1, 16'h2222);
    check("sb_lan2", TX_DATA_HS_LAN2, 16'h3333);
    check("sb_lan3", TX_DATA_HS_LAN3, 16'h4444);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    tick();
    check("sb_one_cycle", valids(), 4'h0);
    check("sb_hold", TX_DATA_HS_LAN0, 16'h1111);
    wait_sig(3, 1'b0, 60, n);

    // Lane 1 slow to reach stop after the burst delays the next start.
    S_VALID = 1'b1;
    S_DATA  = 64'h9999_8888_7777_6666;
    S_LAST  = 1'b1;
    wait_sig(2, 1'b1, 60, n);
    tick();
    stop_lan_en[1] = 1'b0;
    S_DATA = 64'hffff_ffff_ffff_ffff;
    S_LAST = 1'b0;
    wait_sig(0, 1'b0, 40, n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("gap_hold%0d", i), {BUSY, TX_REQUEST_HS}, 2'b10);
    end
    stop_lan_en[1] = 1'b1;
    wait_sig(0, 1'b1, 40, n);
    check("gap_restart", n, GAPC + 2);
    finish_burst(64'h1357_9bdf_0246_8ace);

    // Reset in the middle of an active burst.
    S_VALID = 1'b1;
    S_DATA  = 64'h0bad_f00d_1234_5678;
    S_LAST  = 1'b0;
    wait_sig(2, 1'b1, 60, n);
    tick();
    check("pre_rst_valid", valids(), 4'hf);
    #2;
    RESET = 1'b1;
    #1;
    check("async_req_hs", TX_REQUEST_HS, 1'b0);
    check("async_lane_req", lreqs(), 4'h0);
    check("async_valid", valids(), 4'h0);
    check("async_busy", BUSY, 1'b0);
    check("async_data", lanes(), 64'h0);
    tick();
    RESET = 1'b0;
    tick();
    check("restart_req_hs", TX_REQUEST_HS, 1'b1);
    finish_burst(64'h2468_ace0_1357_9bdf);

    // Randomized bursts against the transaction-level reference.
    do_reset();
    bursts = 0;
    cyc    = 0;
    since  = -1;
    rem    = $urandom_range(1, 6);
    beat   = {$urandom, $urandom};
    prev_d = lanes();
    while (bursts < 40 && cyc < 20000) begin
      set_ready({($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)});
      S_VALID = ($urandom_range(0, 3) != 0);
      S_DATA  = S_VALID ? beat : {$urandom, $urandom};
      S_LAST  = S_VALID ? (rem == 1) : 1'($urandom_range(0, 1));
      #1;
      exp_u = S_READY & ~S_VALID;
      exp_v = S_READY & S_VALID;
      exp_d = exp_v ? S_DATA : prev_d;
      if (S_READY)
        check("rnd_ready_qual",
              {&{TX_READY_HS_LAN3, TX_READY_HS_LAN2, TX_READY_HS_LAN1, TX_READY_HS_LAN0},
               &lreqs(), TX_REQUEST_HS}, 3'b111);
      if (exp_v) begin
        if (S_LAST) begin
          bursts++;
          since = 0;
          rem   = $urandom_range(1, 6);
        end else begin
          rem--;
        end
        beat = {$urandom, $urandom};
      end
      tick();
      cyc++;
      check("rnd_valid", valids(), {4{exp_v}});
      check("rnd_underrun", UNDERRUN, exp_u);
      check("rnd_data", lanes(), exp_d);
      prev_d = lanes();
      if (since >= 0) begin
        since++;
        case (since)
          1:  check("rnd_tail_lane_req", lreqs(), 4'hf);
          2:  check("rnd_drop_lane_req", lreqs(), 4'h0);
          POST + 1: check("rnd_post_req_hs", TX_REQUEST_HS, 1'b1);
          POST + 2: begin
            check("rnd_drop_req_hs", TX_REQUEST_HS, 1'b0);
            since = -1;
          end
          default: ;
        endcase
      end
    end
    if (cyc >= 20000) begin
      total++;
      bad++;
      $display("FAIL rnd_budget: got %0d bursts want 40", bursts);
    end
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    set_ready(4'hf);
    wait_sig(3, 1'b0, 100, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dphy_tx_hs_seq.md
DPHY_TX_HS_SEQ -- requirements
Module: dphy_tx_hs_seq

Interface
REQ-001 Parameter CLK_PRE_CYC, 8, cycles between clock-lane HS request and data-lane HS request (1..255).
REQ-002 Parameter CLK_POST_CYC, 16, cycles the clock lane stays in HS after data lanes drop request (1..255).
REQ-003 Parameter HS_GAP_CYC, 4, minimum LP cycles after all lanes reach stop state before next burst (0..255).
REQ-004 SLOWCLK  in  1  HS byte clock; the only clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 S_VALID  in  1  upstream beat valid.
REQ-007 S_READY  out  1  upstream beat accepted when S_VALID & S_READY.
REQ-008 S_DATA  in  64  beat; [15:0] lane0, [31:16] lane1, [47:32] lane2, [63:48] lane3.
REQ-009 S_LAST  in  1  final beat of HS burst.
REQ-010 TX_REQUEST_HS  out  1  clock-lane HS request.
REQ-011 STOPSTATE_CLK  in  1  clock lane in LP-11.
REQ-012 TX_REQUEST_HS_LAN0..3  out  1 each  data-lane HS request.
REQ-013 TX_READY_HS_LAN0..3  in  1 each  lane ready for HS words.
REQ-014 TX_DATA_HS_LAN0..3  out  16 each  HS word per lane.
REQ-015 TX_WORD_VALID_HS_LAN0..3  out  1 each  word valid per lane.
REQ-016 STOPSTATE_LAN0..3  in  1 each  data lane in LP-11.
REQ-017 BUSY  out  1  high in any state except IDLE.
REQ-018 UNDERRUN  out  1  one-cycle pulse when a mid-burst beat is missing.

Function
REQ-019 States SHALL be IDLE, CLK_PRE, LANE_REQ, ACTIVE, TAIL, CLK_POST, GAP; one shared 8-bit down-counter.
REQ-020 IDLE -> CLK_PRE when S_VALID & STOPSTATE_CLK & all STOPSTATE_LANx; TX_REQUEST_HS rises on the transition cycle; counter loads CLK_PRE_CYC-1.
REQ-021 CLK_PRE: counter decrements; at 0 -> LANE_REQ with all four lane requests asserted together.
REQ-022 LANE_REQ -> ACTIVE when all four TX_READY_HS_LANx high in the same cycle; no timeout.
REQ-023 S_READY SHALL equal (state==ACTIVE) & all TX_READY_HS_LANx; S_READY is 0 in all other states.
REQ-024 Accepted beat at cycle t SHALL appear on TX_DATA_HS_LANx with all four TX_WORD_VALID_HS_LANx high at t+1 (registered, 1-cycle latency).
REQ-025 In ACTIVE with S_READY high and S_VALID low: word valids low at t+1, UNDERRUN pulses at t+1, state stays ACTIVE.
REQ-026 In ACTIVE with any TX_READY_HS_LANx low: no accept, word valids low next cycle, no UNDERRUN.
REQ-027 Accepting S_LAST -> TAIL; in TAIL the last word is output (valids high), lane requests stay high.
REQ-028 TAIL -> CLK_POST after one cycle; all lane requests drop on entry; counter loads CLK_POST_CYC-1; word valids low.
REQ-029 CLK_POST: counter decrements; at 0 -> GAP, TX_REQUEST_HS drops on entry.
REQ-030 GAP: counter held at HS_GAP_CYC until STOPSTATE_CLK and all STOPSTATE_LANx high, then decrements; at 0 (or immediately if HS_GAP_CYC=0) -> IDLE.
REQ-031 TX_DATA_HS_LANx SHALL hold last value when word valid is low.
REQ-032 A burst of one beat (S_LAST on first accepted beat) SHALL follow ACTIVE -> TAIL -> CLK_POST normally.
REQ-033 S_DATA/S_LAST are ignored unless accepted.

Reset
REQ-034 While RESET is high: state IDLE, counter 0, all requests 0, all word valids 0, TX_DATA_HS_LANx 16'h0000, S_READY 0, BUSY 0, UNDERRUN 0.
REQ-035 RESET asserted mid-burst SHALL drop all HS requests asynchronously; after release the block waits in IDLE for stop states per REQ-020.

Verification
REQ-036 Defaults, S_VALID held with 3 beats (last on 3rd), readies high -> TX_REQUEST_HS at t0, lane requests at t0+8, 3 valid words, lane requests low 2 cycles after last accept, TX_REQUEST_HS low 16 cycles later.
REQ-037 S_VALID gap of 2 cycles mid-burst -> 2 UNDERRUN pulses, word valids low 2 cycles, requests stay high.
REQ-038 TX_READY_HS_LAN2 held low 5 cycles after lane request -> state LANE_REQ for 5 cycles, S_READY 0, no data out.
REQ-039 Single beat S_DATA=64'h4444_3333_2222_1111 with S_LAST -> LAN0=16'h1111, LAN1=16'h2222, LAN2=16'h3333, LAN3=16'h4444 for exactly one valid cycle.
REQ-040 STOPSTATE_LAN1 low 10 cycles after burst end -> next burst start delayed until stop + HS_GAP_CYC cycles.
REQ-041 RESET pulsed in ACTIVE -> all requests and valids 0 immediately, BUSY 0, restart clean on next S_VALID.
